// File: rtl/ram_sweep_if.sv
// Access bus for ram_sweep: request side (master) and memory side (slave).
interface ram_sweep_if #(
  parameter int unsigned d_width = 8,
  parameter int unsigned a_width = 8
);
  logic               zero;
  logic               enab;
  logic               rw;
  logic [a_width-1:0] Addr;
  logic [d_width-1:0] data_in;
  logic [d_width-1:0] data_out;
  logic               rd_valid;
  logic               busy;
  logic               rej;

  modport master (
    output zero, enab, rw, Addr, data_in,
    input  data_out, rd_valid, busy, rej
  );

  modport slave (
    input  zero, enab, rw, Addr, data_in,
    output data_out, rd_valid, busy, rej
  );
endinterface

// File: rtl/ram_sweep.sv
// Single-port synchronous RAM with a sequential clear sweep, registered read
// with a valid strobe, reject pulse while busy, and a debug tap of low words.
module ram_sweep #(
  parameter int unsigned d_width = 8,
  parameter int unsigned a_width = 8,
  parameter int unsigned n_taps  = 8
) (
  input  logic                      clk,
  input  logic                      clr,
  ram_sweep_if.slave                bus,
  output logic [n_taps*d_width-1:0] mem_taps
);

  typedef enum logic {StSweep, StReady} state_t;

  state_t             state_q, state_d;
  logic [a_width-1:0] cnt_q, cnt_d;
  logic [d_width-1:0] data_out_q;
  logic               rd_valid_q, rej_q, rej_d;
  logic               rd_en, we;
  logic [a_width-1:0] waddr;
  logic [d_width-1:0] wdata;

  logic [d_width-1:0] mem [2**a_width];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= StSweep;
      cnt_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_en;
      rej_q      <= rej_d;
      if (rd_en) data_out_q <= mem[bus.Addr];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rej_d   = 1'b0;
    rd_en   = 1'b0;
    we      = 1'b0;
    waddr   = bus.Addr;
    wdata   = bus.data_in;
    unique case (state_q)
      StSweep: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        cnt_d = cnt_q + a_width'(1);
        rej_d = bus.enab;
        // Terminate on the all-ones write rather than relying on wrap.
        if (cnt_q == {a_width{1'b1}}) state_d = StReady;
      end
      StReady: begin
        if (bus.zero) begin
          state_d = StSweep;
          cnt_d   = '0;
          rej_d   = bus.enab;
        end else if (bus.enab) begin
          if (bus.rw) we = 1'b1;
          else        rd_en = 1'b1;
        end
      end
      default: state_d = StSweep;
    endcase
  end

  // Array has no reset; gating with clr freezes it while reset is held.
  always_ff @(posedge clk) begin
    if (we && clr) mem[waddr] <= wdata;
  end

  for (genvar k = 0; k < n_taps; k++) begin : g_tap
    assign mem_taps[k*d_width +: d_width] = mem[a_width'(k)];
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rej      = rej_q;
  assign bus.busy     = (state_q == StSweep);

endmodule

// File: tb/tb_ram_sweep.sv
// Directed bench for ram_sweep; reads are scored by a queue-driven monitor.
module tb_ram_sweep;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned NT = 8;

  logic           clk = 1'b0;
  logic           clr = 1'b0;
  logic [NT*DW-1:0] mem_taps;

  ram_sweep_if #(.d_width(DW), .a_width(AW)) bus ();

  ram_sweep #(.d_width(DW), .a_width(AW), .n_taps(NT)) dut (
    .clk      (clk),
    .clr      (clr),
    .bus      (bus),
    .mem_taps (mem_taps)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.zero = 1'b0; bus.enab = 1'b0; bus.rw = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.enab = 1'b1; bus.rw = 1'b1; bus.Addr = a; bus.data_in = d;
    tick();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bus.enab = 1'b1; bus.rw = 1'b0; bus.Addr = a;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'd16);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) rd(AW'(i), 8'h00);
    idle();
  endtask

  // Monitor: every rd_valid must match the oldest pending expected read.
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      check("rd_valid/rej exclusive", 64'(bus.rej), 64'd0);
      if (exp_q.size() == 0) check("rd_valid without pending read", 64'(bus.rd_valid), 64'd0);
      else check("read data", 64'(bus.data_out), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    idle();
    bus.Addr = '0; bus.data_in = '0;
    tick(); tick();
    check("reset busy", 64'(bus.busy), 64'd1);
    check("reset data_out", 64'(bus.data_out), 64'd0);
    check("reset rd_valid", 64'(bus.rd_valid), 64'd0);
    check("reset rej", 64'(bus.rej), 64'd0);
    clr = 1'b1;
    count_busy("reset sweep length");
    check("taps after sweep", mem_taps, 64'd0);
    read_all_zero();

    // Write then read, tap visible right after the write edge.
    wr(4'd3, 8'hA5);
    check("tap3 after write", 64'(mem_taps[3*DW +: DW]), 64'hA5);
    check("no rd_valid on write", 64'(bus.rd_valid), 64'd0);
    rd(4'd3, 8'hA5);
    idle();
    tick();
    check("rd_valid single cycle", 64'(bus.rd_valid), 64'd0);

    // Back-to-back reads, then hold.
    wr(4'd0, 8'h11);
    wr(4'd1, 8'h22);
    rd(4'd0, 8'h11);
    rd(4'd1, 8'h22);
    rd(4'd0, 8'h11);
    idle();
    tick(); tick();
    check("data_out hold", 64'(bus.data_out), 64'h11);
    check("rd_valid idle", 64'(bus.rd_valid), 64'd0);

    // zero beats a simultaneous read; busy/rej behaviour during sweep.
    wr(4'd5, 8'h55);
    wr(4'd15, 8'hF0);
    check("taps before zero", mem_taps, 64'h0000_5500_A500_2211);
    bus.zero = 1'b1; bus.enab = 1'b1; bus.rw = 1'b0; bus.Addr = 4'd3;
    tick();
    idle();
    check("rej on zero+access", 64'(bus.rej), 64'd1);
    check("busy after zero", 64'(bus.busy), 64'd1);
    begin
      int n = 0;
      while (bus.busy && n < 100) begin
        if (n == 4) begin bus.enab = 1'b1; bus.rw = 1'b1; bus.Addr = 4'd5; bus.data_in = 8'hFF; end
        if (n == 8) bus.zero = 1'b1;
        tick();
        n++;
        idle();
        if (n == 5) check("rej during sweep", 64'(bus.rej), 64'd1);
        if (n == 6) check("rej single cycle", 64'(bus.rej), 64'd0);
      end
      check("zero sweep length", 64'(n), 64'd16);
    end
    check("taps after zero", mem_taps, 64'd0);
    read_all_zero();

    // Reset mid-sweep: counter restarts, unswept words keep data until reached.
    wr(4'd7, 8'h66);
    wr(4'd9, 8'h77);
    bus.zero = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 7; i++) tick();
    clr = 1'b0;
    tick(); tick();
    check("mid reset busy", 64'(bus.busy), 64'd1);
    check("mid reset data_out", 64'(bus.data_out), 64'd0);
    check("tap7 retained", 64'(mem_taps[7*DW +: DW]), 64'h66);
    clr = 1'b1;
    count_busy("sweep after mid reset");
    rd(4'd7, 8'h00);
    rd(4'd9, 8'h00);
    idle();
    tick(); tick();
    check("pending reads", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
